// File: rtl/seq_mult_shift_add.sv
// Unsigned sequential shift-and-add multiplier, one partial product per clock.
// Optional MULT_ZERO_BYPASS_EN: zero operands skip RUN and go straight to DONE.
`timescale 1ns/1ps

module xor2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module and2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module or2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module seq_mult_shift_add #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_hi;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   hs;
    logic [WIDTH-1:0]   gen;
    logic [WIDTH-1:0]   prop;
    logic [WIDTH:0]     carry;
    logic               cout;
    logic [2*WIDTH-1:0] nxt;
    logic               bypass;

    assign addend   = mplier[0] ? mcand : '0;
    assign carry[0] = 1'b0;
    assign cout     = carry[WIDTH];

    // Ripple-carry chain: each bit is a gate-level full adder.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        xor2 u_x0 (.a(acc_hi[i]), .b(addend[i]), .y(hs[i]));
        xor2 u_x1 (.a(hs[i]),     .b(carry[i]),  .y(sum[i]));
        and2 u_a0 (.a(acc_hi[i]), .b(addend[i]), .y(gen[i]));
        and2 u_a1 (.a(hs[i]),     .b(carry[i]),  .y(prop[i]));
        or2  u_o0 (.a(gen[i]),    .b(prop[i]),   .y(carry[i+1]));
    end

    // {cout,sum,mplier} shifted right by one, keeping the carry-out.
    assign nxt = {cout, sum, mplier[WIDTH-1:1]};

`ifdef MULT_ZERO_BYPASS_EN
    assign bypass = (a == '0) || (b == '0);
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc_hi <= '0;
            cnt    <= '0;
            p      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc_hi <= '0;
                        cnt    <= '0;
                        if (bypass) begin
                            state <= DONE;
                            done  <= 1'b1;
                            p     <= '0;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_hi <= nxt[2*WIDTH-1:WIDTH];
                    mplier <= nxt[WIDTH-1:0];
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        p     <= nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Self-checking bench for seq_mult_shift_add (WIDTH=4, 1 ns clock).
// Expected products come from plain a*b; timing from the documented latency.
`timescale 1ns/1ps

module tb_seq_mult_shift_add;

    localparam int W = 4;

`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int errors = 0;
    int checks = 0;

    seq_mult_shift_add #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #0.5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts an op at the current negedge; returns at the negedge where
    // done is seen (or the bound expires). pulse_at>0 injects a start
    // request during RUN that must be ignored.
    task automatic do_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                           input int pulse_at);
        logic [2*W-1:0] exp_p;
        int n;
        int busy_cnt;
        int exp_lat;
        int exp_busy;
        bit zero;
        exp_p    = (2*W)'(x) * (2*W)'(y);
        zero     = (x == 0) || (y == 0);
        exp_lat  = (BYP && zero) ? 1 : W + 1;
        exp_busy = (BYP && zero) ? 0 : W;
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) busy_cnt++;
            start = (n == pulse_at);
            a = (n == pulse_at) ? W'(2) : ~x;
            b = (n == pulse_at) ? W'(3) : ~y;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", 32'(n), 32'(exp_lat));
        chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("product", 32'(p), 32'(exp_p));
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;

        // reset and idle
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_p", 32'(p), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_p", 32'(p), 32'd0);
        end

        // basic op, done one cycle, product holds
        do_mult(4'd13, 4'd11, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_done", 32'(done), 32'd0);
            chk("hold_p", 32'(p), 32'd143);
        end

        // max operands then back-to-back start in DONE
        do_mult(4'd15, 4'd15, 0);
        do_mult(4'd3, 4'd5, 0);
        @(negedge clk);
        chk("b2b_done_low", 32'(done), 32'd0);

        // start during RUN ignored
        do_mult(4'd6, 4'd7, 2);
        @(negedge clk);

        // reset mid-operation
        a = 4'd9;
        b = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        #0.25 reset = 1'b1;
        #0.1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_p", 32'(p), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_p", 32'(p), 32'd0);
        do_mult(4'd5, 4'd4, 0);
        @(negedge clk);

        // zero operand
        do_mult(4'd0, 4'd9, 0);
        @(negedge clk);
        do_mult(4'd7, 4'd0, 0);
        @(negedge clk);

        // randomized ops, randomly chained back-to-back
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom_range(0, 15));
            y = W'($urandom_range(0, 15));
            do_mult(x, y, 0);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk("rnd_done_low", 32'(done), 32'd0);
            end
        end

        // exhaustive sweep, chained back-to-back
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_mult(W'(i), W'(j), 0);
            end
        end
        @(negedge clk);
        chk("final_done_low", 32'(done), 32'd0);
        chk("final_p", 32'(p), 32'd225);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
